mem_arbiter: RTL

- Sequences one shared single-port, variable-latency unified memory between the multi-cycle core's two requesters.
- The instruction-fetch port is used in the fetch state. The data port is used in the lw/lb/sw/sb memory states.
- Round-robin arbitration on simultaneous requests.
- Handles byte lanes for lb/sb, rejects misaligned accesses, and aborts stalled accesses with a timeout error.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared unified-memory sequencer for the fetch and data ports.
// Round-robin on ties, byte lanes, misalign rejection, stall timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_isbyte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_en,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_d;

  // gnt_q/last_gnt: 0 = fetch, 1 = data
  logic        gnt_q;
  logic        last_gnt;
  logic        we_q;
  logic        isbyte_q;
  logic        err_q;
  logic [1:0]  lane_q;
  logic [29:0] waddr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt;

  logic        any_req;
  logic        sel;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        sel_byte;
  logic        sel_mis;
  logic        tmo;
  logic        fin;
  logic [7:0]  rbyte;
  logic [31:0] rd_val;

  always_comb begin
    any_req = i_req | d_req;
    if (i_req && d_req) sel = ~last_gnt;
    else                sel = d_req;
    sel_addr = sel ? d_addr : i_addr;
    sel_we   = sel & d_we;
    sel_byte = sel & d_isbyte;
    sel_mis  = (sel_addr[1:0] != 2'b00) && !sel_byte;
  end

  always_comb begin
    tmo = !m_ready && (cnt == 8'(TIMEOUT - 1));
    fin = m_ready || tmo;
    unique case (lane_q)
      2'd0:    rbyte = m_rdata[7:0];
      2'd1:    rbyte = m_rdata[15:8];
      2'd2:    rbyte = m_rdata[23:16];
      default: rbyte = m_rdata[31:24];
    endcase
    if (isbyte_q) rd_val = {{24{rbyte[7]}}, rbyte};
    else          rd_val = m_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (any_req) state_d = sel_mis ? DONE : ACCESS;
      ACCESS:  if (fin) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      isbyte_q <= 1'b0;
      err_q    <= 1'b0;
      lane_q   <= 2'd0;
      waddr_q  <= 30'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      cnt      <= 8'd0;
      i_rdata  <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          gnt_q    <= sel;
          last_gnt <= sel;
          we_q     <= sel_we;
          isbyte_q <= sel_byte;
          err_q    <= sel_mis;
          lane_q   <= sel_addr[1:0];
          waddr_q  <= sel_addr[31:2];
          be_q     <= sel_byte ? 4'b0001 << sel_addr[1:0] : 4'hF;
          wdata_q  <= sel_byte ? {4{d_wdata[7:0]}} : d_wdata;
          cnt      <= 8'd0;
          if (sel_mis && !sel_we) begin
            if (sel) d_rdata <= ERR_DATA;
            else     i_rdata <= ERR_DATA;
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          if (fin) begin
            err_q <= !m_ready;
            if (!we_q) begin
              if (gnt_q) d_rdata <= m_ready ? rd_val : ERR_DATA;
              else       i_rdata <= m_ready ? m_rdata : ERR_DATA;
            end
          end
        end
        DONE:    cnt <= 8'd0;
        default: cnt <= 8'd0;
      endcase
    end
  end

  always_comb begin
    m_en    = (state == ACCESS);
    m_we    = m_en & we_q;
    m_be    = m_en ? be_q : 4'd0;
    m_addr  = m_en ? waddr_q : 30'd0;
    m_wdata = m_en ? wdata_q : 32'd0;
    i_done  = (state == DONE) & ~gnt_q;
    d_done  = (state == DONE) & gnt_q;
    err     = (state == DONE) & err_q;
    busy    = (state != IDLE);
  end

endmodule
